// File: rtl/cae_disp_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cae_disp_ctl
// Brief    : Dispatch controller. Holds the AEG register file (host-writable
//            low registers, read-only GVT and statistics above RO_BASE),
//            sequences IDLE/RUNNING/FINISHED runs with an optional timeout,
//            and reports exceptions. Optional debug CSR read port is built
//            only when CAE_DISP_CTL_CSR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cae_disp_ctl #(
    parameter int NA     = 16,
    parameter int NSTAT  = 9,
    parameter int TO_IDX = 1
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  disp_inst_vld,
    input  logic [4:0]            disp_inst,
    input  logic [17:0]           disp_aeg_idx,
    input  logic                  disp_aeg_rd,
    input  logic                  disp_aeg_wr,
    input  logic [63:0]           disp_aeg_wr_data,
    output logic [17:0]           disp_aeg_cnt,
    output logic [15:0]           disp_exception,
    output logic                  disp_idle,
    output logic                  disp_stall,
    output logic                  disp_rtn_data_vld,
    output logic [63:0]           disp_rtn_data,
    input  logic [3:0]            i_aeid,
    input  logic                  core_done,
    input  logic [15:0]           core_gvt,
    input  logic                  stat_vld,
    input  logic [NSTAT*64-1:0]   stat_data,
    output logic                  core_rst_n,
    output logic [NA*64-1:0]      aeg_flat,
    input  logic                  csr_rd_vld,
    input  logic [15:0]           csr_address,
    output logic                  csr_rd_ack,
    output logic [63:0]           csr_rd_data
);

    // First read-only AEG: GVT lives here, statistics channels follow it
    localparam int RO_BASE = NA - NSTAT - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_caep00;
    logic [31:0] r_cnt;
    logic [63:0] r_gvt;
    logic [63:0] r_stat [NSTAT];
    logic [63:0] r_aeg  [RO_BASE];
    logic        r_core_rst_n;
    logic        r_rtn_vld;
    logic [63:0] r_rtn_data;
    logic [1:0]  r_exc_lo;
    logic        r_exc_to;

    logic [63:0] w_aeg [NA];
    logic [63:0] w_rd_data;
    logic        w_caep00;
    logic        w_idx_bad;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_limit;
    logic        w_timeout;

    // Assemble the full AEG view from writable, GVT and statistics storage
    genvar g;
    generate
        for (g = 0; g < NA; g++) begin : g_aeg
            if (g < RO_BASE) begin : g_rw
                assign w_aeg[g] = r_aeg[g];
            end else if (g == RO_BASE) begin : g_gvt
                assign w_aeg[g] = r_gvt;
            end else begin : g_stat
                assign w_aeg[g] = r_stat[g - RO_BASE - 1];
            end
            assign aeg_flat[64*g +: 64] = w_aeg[g];
        end
    endgenerate

    assign w_caep00  = disp_inst_vld && (disp_inst == 5'd0);
    assign w_idx_bad = (disp_aeg_rd || disp_aeg_wr) && (disp_aeg_idx >= 18'(NA));
    assign w_cnt_nxt = r_cnt + 32'd1;
    assign w_limit   = w_aeg[TO_IDX][31:0];
    // Counter holds the number of RUNNING cycles completed, so the run ends
    // after exactly 'limit' RUNNING cycles
    assign w_timeout = (w_limit != 32'd0) && (w_cnt_nxt == w_limit);

    // Host read mux; out-of-range indices return zero
    always_comb begin
        w_rd_data = 64'd0;
        for (int i = 0; i < NA; i++) begin
            if (disp_aeg_idx == 18'(i)) begin
                w_rd_data = w_aeg[i];
            end
        end
    end

    // Dispatch side: writes, read returns, caep00 capture, decode exceptions
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_caep00   <= 1'b0;
            r_rtn_vld  <= 1'b0;
            r_rtn_data <= 64'd0;
            r_exc_lo   <= 2'b00;
            for (int i = 0; i < RO_BASE; i++) begin
                r_aeg[i] <= 64'd0;
            end
        end else begin
            r_caep00  <= w_caep00;
            r_rtn_vld <= disp_aeg_rd;
            if (disp_aeg_rd) begin
                r_rtn_data <= w_rd_data;
            end
            r_exc_lo  <= {w_idx_bad, disp_inst_vld && (disp_inst != 5'd0)};
            for (int i = 0; i < RO_BASE; i++) begin
                if (disp_aeg_wr && (disp_aeg_idx == 18'(i))) begin
                    r_aeg[i] <= disp_aeg_wr_data;
                end
            end
        end
    end

    // Statistics snapshot: load every channel whenever the core presents one
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NSTAT; k++) begin
                r_stat[k] <= 64'd0;
            end
        end else if (stat_vld) begin
            for (int k = 0; k < NSTAT; k++) begin
                r_stat[k] <= stat_data[64*k +: 64];
            end
        end
    end

    // Run sequencer; core_done wins over a coincident timeout
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 32'd0;
            r_gvt        <= 64'd0;
            r_exc_to     <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_exc_to <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_caep00) begin
                        r_state      <= ST_RUNNING;
                        r_cnt        <= 32'd0;
                        r_core_rst_n <= (i_aeid == 4'd0);
                    end
                end
                ST_RUNNING: begin
                    r_cnt <= w_cnt_nxt;
                    if (i_aeid != 4'd0) begin
                        r_state      <= ST_FINISHED;
                        r_core_rst_n <= 1'b0;
                    end else if (core_done) begin
                        r_state      <= ST_FINISHED;
                        r_gvt        <= {48'd0, core_gvt};
                        r_core_rst_n <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= ST_FINISHED;
                        r_gvt        <= 64'hFFFF;
                        r_exc_to     <= 1'b1;
                        r_core_rst_n <= 1'b0;
                    end else begin
                        r_core_rst_n <= 1'b1;
                    end
                end
                ST_FINISHED: begin
                    r_state      <= ST_IDLE;
                    r_core_rst_n <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAE_DISP_CTL_CSR_EN
    logic        r_csr_ack;
    logic [63:0] r_csr_data;

    // Debug CSR read: state, GVT and run counter, one-cycle latency
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_csr_ack  <= 1'b0;
            r_csr_data <= 64'd0;
        end else begin
            r_csr_ack <= csr_rd_vld;
            if (csr_rd_vld) begin
                case (csr_address)
                    16'h0:   r_csr_data <= {62'd0, r_state};
                    16'h1:   r_csr_data <= r_gvt;
                    16'h2:   r_csr_data <= {32'd0, r_cnt};
                    default: r_csr_data <= 64'd0;
                endcase
            end
        end
    end

    assign csr_rd_ack  = r_csr_ack;
    assign csr_rd_data = r_csr_data;
`else
    logic w_unused_csr;
    assign w_unused_csr = &{1'b0, csr_rd_vld, csr_address};
    assign csr_rd_ack   = 1'b0;
    assign csr_rd_data  = 64'd0;
`endif

    assign disp_aeg_cnt      = 18'(NA);
    assign disp_exception    = {13'd0, r_exc_to, r_exc_lo};
    assign disp_idle         = (r_state == ST_IDLE) && !r_caep00;
    assign disp_stall        = (r_state != ST_IDLE) || w_caep00 || r_caep00;
    assign disp_rtn_data_vld = r_rtn_vld;
    assign disp_rtn_data     = r_rtn_data;
    assign core_rst_n        = r_core_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_cae_disp_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cae_disp_ctl
// Brief    : Directed self-checking bench for cae_disp_ctl (default params)
// Revision : 1.0 - initial release
// ============================================================================
module tb_cae_disp_ctl;

    localparam int NA      = 16;
    localparam int NSTAT   = 9;
    localparam int RO_BASE = NA - NSTAT - 1;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                disp_inst_vld;
    logic [4:0]          disp_inst;
    logic [17:0]         disp_aeg_idx;
    logic                disp_aeg_rd;
    logic                disp_aeg_wr;
    logic [63:0]         disp_aeg_wr_data;
    logic [17:0]         disp_aeg_cnt;
    logic [15:0]         disp_exception;
    logic                disp_idle;
    logic                disp_stall;
    logic                disp_rtn_data_vld;
    logic [63:0]         disp_rtn_data;
    logic [3:0]          i_aeid;
    logic                core_done;
    logic [15:0]         core_gvt;
    logic                stat_vld;
    logic [NSTAT*64-1:0] stat_data;
    logic                core_rst_n;
    logic [NA*64-1:0]    aeg_flat;
    logic                csr_rd_vld;
    logic [15:0]         csr_address;
    logic                csr_rd_ack;
    logic [63:0]         csr_rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    cae_disp_ctl #(.NA(NA), .NSTAT(NSTAT), .TO_IDX(1)) u_dut (
        .clk               (clk),
        .i_reset           (i_reset),
        .disp_inst_vld     (disp_inst_vld),
        .disp_inst         (disp_inst),
        .disp_aeg_idx      (disp_aeg_idx),
        .disp_aeg_rd       (disp_aeg_rd),
        .disp_aeg_wr       (disp_aeg_wr),
        .disp_aeg_wr_data  (disp_aeg_wr_data),
        .disp_aeg_cnt      (disp_aeg_cnt),
        .disp_exception    (disp_exception),
        .disp_idle         (disp_idle),
        .disp_stall        (disp_stall),
        .disp_rtn_data_vld (disp_rtn_data_vld),
        .disp_rtn_data     (disp_rtn_data),
        .i_aeid            (i_aeid),
        .core_done         (core_done),
        .core_gvt          (core_gvt),
        .stat_vld          (stat_vld),
        .stat_data         (stat_data),
        .core_rst_n        (core_rst_n),
        .aeg_flat          (aeg_flat),
        .csr_rd_vld        (csr_rd_vld),
        .csr_address       (csr_address),
        .csr_rd_ack        (csr_rd_ack),
        .csr_rd_data       (csr_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] aeg(input int idx);
        return aeg_flat[64*idx +: 64];
    endfunction

    // Pulse caep00 for one cycle; stall must rise combinationally
    task automatic caep_pulse();
        disp_inst_vld = 1'b1;
        disp_inst     = 5'd0;
        #1;
        check("stall_comb", {63'd0, disp_stall}, 64'd1);
        tick();
        disp_inst_vld = 1'b0;
    endtask

    task automatic aeg_write(input int idx, input logic [63:0] data);
        disp_aeg_wr      = 1'b1;
        disp_aeg_idx     = 18'(idx);
        disp_aeg_wr_data = data;
        tick();
        disp_aeg_wr      = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; disp_inst_vld = 1'b0; disp_inst = 5'd0;
        disp_aeg_idx = 18'd0; disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0;
        disp_aeg_wr_data = 64'd0; i_aeid = 4'd0; core_done = 1'b0;
        core_gvt = 16'd0; stat_vld = 1'b0; stat_data = '0;
        csr_rd_vld = 1'b0; csr_address = 16'd0;
        repeat (3) tick();

        // Reset state
        check("rst_idle",   {63'd0, disp_idle}, 64'd1);
        check("rst_stall",  {63'd0, disp_stall}, 64'd0);
        check("rst_corerst", {63'd0, core_rst_n}, 64'd0);
        check("rst_exc",    {48'd0, disp_exception}, 64'd0);
        check("rst_rtnvld", {63'd0, disp_rtn_data_vld}, 64'd0);
        check("rst_aegzero", {63'd0, aeg_flat == '0}, 64'd1);
        check("aeg_cnt",    {46'd0, disp_aeg_cnt}, 64'd16);
        i_reset = 1'b0;
        tick();

        // Write / read AEG 0
        aeg_write(0, 64'hDEAD);
        check("wr_aeg0", aeg(0), 64'hDEAD);
        disp_aeg_rd = 1'b1; disp_aeg_idx = 18'd0;
        tick();
        disp_aeg_rd = 1'b0;
        check("rd0_vld",  {63'd0, disp_rtn_data_vld}, 64'd1);
        check("rd0_data", disp_rtn_data, 64'hDEAD);
        tick();
        check("rd0_vld_end", {63'd0, disp_rtn_data_vld}, 64'd0);

        // Out-of-range read
        disp_aeg_rd = 1'b1; disp_aeg_idx = 18'(NA);
        tick();
        disp_aeg_rd = 1'b0;
        check("rdNA_vld",  {63'd0, disp_rtn_data_vld}, 64'd1);
        check("rdNA_data", disp_rtn_data, 64'd0);
        check("rdNA_exc",  {48'd0, disp_exception}, 64'h2);
        tick();
        check("rdNA_exc_end", {48'd0, disp_exception}, 64'd0);

        // Read-only GVT ignores host writes
        aeg_write(RO_BASE, 64'h5);
        check("ro_write", aeg(RO_BASE), 64'd0);

        // Statistics snapshot then hold
        for (int k = 0; k < NSTAT; k++) stat_data[64*k +: 64] = 64'(k + 1);
        stat_vld = 1'b1;
        tick();
        stat_vld = 1'b0;
        stat_data = '1;
        check("stat0", aeg(RO_BASE + 1), 64'd1);
        disp_aeg_rd = 1'b1; disp_aeg_idx = 18'(NA - 1);
        tick();
        disp_aeg_rd = 1'b0;
        check("stat8_rd", disp_rtn_data, 64'd9);
        check("stat8_hold", aeg(NA - 1), 64'd9);

        // Bad instruction
        disp_inst_vld = 1'b1; disp_inst = 5'd3;
        tick();
        disp_inst_vld = 1'b0; disp_inst = 5'd0;
        check("badinst_exc", {48'd0, disp_exception}, 64'h1);
        tick();
        check("badinst_exc_end", {48'd0, disp_exception}, 64'd0);

        // Normal run: core_done after 50 RUNNING cycles
        caep_pulse();
        check("run1_idle_lo", {63'd0, disp_idle}, 64'd0);
        tick();
        check("run1_corerst", {63'd0, core_rst_n}, 64'd1);
        repeat (49) tick();
        core_done = 1'b1; core_gvt = 16'h1234;
        tick();
        core_done = 1'b0;
        check("run1_gvt", aeg(RO_BASE), 64'h1234);
        check("run1_fin_idle", {63'd0, disp_idle}, 64'd0);
        check("run1_fin_corerst", {63'd0, core_rst_n}, 64'd0);
        tick();
        check("run1_idle", {63'd0, disp_idle}, 64'd1);
        check("run1_exc", {48'd0, disp_exception}, 64'd0);

        // Timeout run: limit 100
        aeg_write(1, 64'd100);
        caep_pulse();
        tick();
        repeat (99) tick();
        check("to_still_run", {63'd0, core_rst_n}, 64'd1);
        check("to_no_exc_yet", {48'd0, disp_exception}, 64'd0);
        tick();
        check("to_gvt", aeg(RO_BASE), 64'hFFFF);
        check("to_exc", {48'd0, disp_exception}, 64'h4);
        check("to_corerst", {63'd0, core_rst_n}, 64'd0);
        tick();
        check("to_exc_end", {48'd0, disp_exception}, 64'd0);
        check("to_idle", {63'd0, disp_idle}, 64'd1);

        // Non-zero AE: core never enabled, back to IDLE 3 cycles after r_caep00
        i_aeid = 4'd3;
        caep_pulse();
        check("ae3_corerst0", {63'd0, core_rst_n}, 64'd0);
        tick();
        check("ae3_corerst1", {63'd0, core_rst_n}, 64'd0);
        check("ae3_busy", {63'd0, disp_idle}, 64'd0);
        tick();
        check("ae3_fin_busy", {63'd0, disp_idle}, 64'd0);
        tick();
        check("ae3_idle", {63'd0, disp_idle}, 64'd1);
        check("ae3_gvt", aeg(RO_BASE), 64'hFFFF);
        i_aeid = 4'd0;

        // core_done coincides with timeout: done wins
        caep_pulse();
        tick();
        repeat (99) tick();
        core_done = 1'b1; core_gvt = 16'hBEEF;
        tick();
        core_done = 1'b0;
        check("co_gvt", aeg(RO_BASE), 64'hBEEF);
        check("co_exc", {48'd0, disp_exception}, 64'd0);
        tick();
        check("co_exc2", {48'd0, disp_exception}, 64'd0);
        check("co_idle", {63'd0, disp_idle}, 64'd1);

        // Reset while RUNNING
        caep_pulse();
        tick();
        repeat (5) tick();
        i_reset = 1'b1;
        #1;
        check("ar_corerst", {63'd0, core_rst_n}, 64'd0);
        check("ar_idle", {63'd0, disp_idle}, 64'd1);
        check("ar_stall", {63'd0, disp_stall}, 64'd0);
        check("ar_aegzero", {63'd0, aeg_flat == '0}, 64'd1);
        check("ar_exc", {48'd0, disp_exception}, 64'd0);
        tick();
        i_reset = 1'b0;
        tick();
        check("ar_exc_after", {48'd0, disp_exception}, 64'd0);
        check("ar_idle_after", {63'd0, disp_idle}, 64'd1);
        caep_pulse();
        tick();
        check("clean_corerst", {63'd0, core_rst_n}, 64'd1);
        repeat (4) tick();
        core_done = 1'b1; core_gvt = 16'h0055;
        tick();
        core_done = 1'b0;
        check("clean_gvt", aeg(RO_BASE), 64'h55);
        check("clean_exc", {48'd0, disp_exception}, 64'd0);
        tick();
        check("clean_idle", {63'd0, disp_idle}, 64'd1);

        // Debug CSR port
        csr_rd_vld = 1'b1; csr_address = 16'h1;
        tick();
        csr_rd_vld = 1'b0;
`ifdef CAE_DISP_CTL_CSR_EN
        check("csr_ack", {63'd0, csr_rd_ack}, 64'd1);
        check("csr_gvt", csr_rd_data, 64'h55);
`else
        check("csr_ack", {63'd0, csr_rd_ack}, 64'd0);
        check("csr_data", csr_rd_data, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
